// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared codes for the memory stage: funct3 sizes, writeback
//            selects, FSM states and the misalignment predicate.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_SEL_ALU = 2'b00;
    localparam logic [1:0] c_SEL_MEM = 2'b01;
    localparam logic [1:0] c_SEL_PC4 = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic r;
        r = 1'b0;
        case (f3)
            c_F3_H, c_F3_HU: r = lo[0];
            c_F3_W:          r = (lo != 2'b00);
            default:         r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational store lane/byte-enable generation and load
//            extraction with sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_load_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_val
);

    logic [31:0] w_shifted;

    assign w_shifted = i_load_data >> {i_addr_lo, 3'b000};

    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_store_data;
            end
        endcase
    end

    // Word loads ignore the low address bits (they are masked, not shifted).
    always_comb begin
        o_load_val = i_load_data;
        case (i_funct3)
            c_F3_B:  o_load_val = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_F3_H:  o_load_val = {{16{w_shifted[15]}}, w_shifted[15:0]};
            c_F3_BU: o_load_val = {24'd0, w_shifted[7:0]};
            c_F3_HU: o_load_val = {16'd0, w_shifted[15:0]};
            default: o_load_val = i_load_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory stage: branch resolution, request/ready data
//            port with stall FSM, and the MEM/WB register.
//            Optional macro MEM_MISALIGN_TRAP_EN suppresses misaligned H/W
//            accesses and pulses misalign_o.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           MEM_pc_i,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_rs2_data_i,
    input  logic [4:0]            MEM_rd_add_i,
    input  logic [1:0]            MEM_sel_to_reg_i,
    input  logic                  MEM_regwrite_i,
    input  logic                  MEM_RD_mem_i,
    input  logic                  MEM_WR_mem_i,
    input  logic [3:0]            MEM_mem_op_i,
    input  logic                  MEM_zero_i,
    input  logic                  MEM_branch_i,
    input  logic                  MEM_jump_i,
    input  logic [31:0]           MEM_pc_dest_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [3:0]            dmem_be_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    input  logic                  dmem_ready_i,
    output logic                  stall_o,
    output logic                  pc_src_o,
    output logic [31:0]           pc_dest_o,
    output logic [DATA_WIDTH-1:0] MEM_fwd_data_o,
    output logic [4:0]            WB_rd_add_o,
    output logic                  WB_regwrite_o,
    output logic [DATA_WIDTH-1:0] WB_wdata_o,
    output logic                  misalign_o
);

    state_t      r_state, w_next;

    logic [31:0] r_alu, r_wdata, r_pc;
    logic [3:0]  r_be;
    logic        r_we, r_rw;
    logic [2:0]  r_f3;
    logic [4:0]  r_rd;
    logic [1:0]  r_sel;

    logic [4:0]  r_wb_rd;
    logic        r_wb_rw;
    logic [31:0] r_wb_data;

    logic        w_acc, w_mis, w_issue, w_wait, w_wb_en, w_unused;
    logic [1:0]  w_lo, w_sel;
    logic [2:0]  w_f3;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_wdata, w_load_val, w_alu, w_pc, w_wb_data;
    logic [4:0]  w_rd;

    assign w_unused = &{1'b0, MEM_mem_op_i[3]};

    assign w_acc  = MEM_RD_mem_i | MEM_WR_mem_i;
    assign w_wait = (r_state == WAIT);

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_mis;
    assign w_mis      = w_acc & is_misaligned(MEM_mem_op_i[2:0], MEM_alu_result_i[1:0]);
    assign misalign_o = r_mis;
    always_ff @(posedge clk) begin
        if (rst) r_mis <= 1'b0;
        else     r_mis <= ~w_wait & w_mis;
    end
`else
    assign w_mis      = 1'b0;
    assign misalign_o = 1'b0;
`endif

    assign w_issue = w_acc & ~w_mis;

    // While waiting, load extraction must follow the latched access, not the
    // (frozen but conceptually unowned) EX/MEM inputs.
    assign w_lo = w_wait ? r_alu[1:0] : MEM_alu_result_i[1:0];
    assign w_f3 = w_wait ? r_f3 : MEM_mem_op_i[2:0];

    lsu_align u_lsu_align (
        .i_addr_lo    (w_lo),
        .i_funct3     (w_f3),
        .i_store_data (MEM_rs2_data_i),
        .i_load_data  (dmem_rdata_i),
        .o_be         (w_st_be),
        .o_wdata      (w_st_wdata),
        .o_load_val   (w_load_val)
    );

    assign pc_src_o       = ~rst & (MEM_jump_i | (MEM_branch_i & MEM_zero_i));
    assign pc_dest_o      = MEM_pc_dest_i;
    assign MEM_fwd_data_o = MEM_alu_result_i;

    always_comb begin
        w_next       = r_state;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = {MEM_alu_result_i[ADDR_WIDTH-1:2], 2'b00};
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = w_st_wdata;
        stall_o      = 1'b0;
        w_wb_en      = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    w_wb_en = MEM_regwrite_i & ~MEM_WR_mem_i & ~w_mis;
                    if (w_issue) begin
                        dmem_req_o = 1'b1;
                        dmem_we_o  = MEM_WR_mem_i;
                        dmem_be_o  = w_st_be;
                        if (!dmem_ready_i) begin
                            stall_o = 1'b1;
                            w_wb_en = 1'b0;
                            w_next  = WAIT;
                        end
                    end
                end
                WAIT: begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = r_we;
                    dmem_addr_o  = {r_alu[ADDR_WIDTH-1:2], 2'b00};
                    dmem_be_o    = r_be;
                    dmem_wdata_o = r_wdata;
                    if (dmem_ready_i) begin
                        w_wb_en = r_rw;
                        w_next  = IDLE;
                    end else begin
                        stall_o = 1'b1;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    assign w_rd  = w_wait ? r_rd  : MEM_rd_add_i;
    assign w_sel = w_wait ? r_sel : MEM_sel_to_reg_i;
    assign w_alu = w_wait ? r_alu : MEM_alu_result_i;
    assign w_pc  = w_wait ? r_pc  : MEM_pc_i;

    always_comb begin
        w_wb_data = w_alu;
        case (w_sel)
            c_SEL_MEM: w_wb_data = w_load_val;
            c_SEL_PC4: w_wb_data = w_pc + 32'd4;
            default:   w_wb_data = w_alu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wb_rd   <= 5'd0;
            r_wb_rw   <= 1'b0;
            r_wb_data <= 32'd0;
        end else begin
            r_state   <= w_next;
            r_wb_rd   <= w_rd;
            r_wb_rw   <= w_wb_en;
            r_wb_data <= w_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_we <= 1'b0;
            r_rw <= 1'b0;
        end else if (!w_wait && w_issue && !dmem_ready_i) begin
            r_alu   <= MEM_alu_result_i;
            r_be    <= w_st_be;
            r_wdata <= w_st_wdata;
            r_we    <= MEM_WR_mem_i;
            r_rw    <= MEM_regwrite_i & ~MEM_WR_mem_i;
            r_f3    <= MEM_mem_op_i[2:0];
            r_rd    <= MEM_rd_add_i;
            r_sel   <= MEM_sel_to_reg_i;
            r_pc    <= MEM_pc_i;
        end
    end

    assign WB_rd_add_o   = r_wb_rd;
    assign WB_regwrite_o = r_wb_rw;
    assign WB_wdata_o    = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Scoreboard bench for mem_stage with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk, rst;
    logic [31:0] MEM_pc_i, MEM_alu_result_i, MEM_rs2_data_i, MEM_pc_dest_i;
    logic [4:0]  MEM_rd_add_i;
    logic [1:0]  MEM_sel_to_reg_i;
    logic        MEM_regwrite_i, MEM_RD_mem_i, MEM_WR_mem_i;
    logic [3:0]  MEM_mem_op_i;
    logic        MEM_zero_i, MEM_branch_i, MEM_jump_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
    logic [3:0]  dmem_be_o;
    logic        dmem_ready_i, stall_o, pc_src_o;
    logic [31:0] pc_dest_o, MEM_fwd_data_o, WB_wdata_o;
    logic [4:0]  WB_rd_add_o;
    logic        WB_regwrite_o, misalign_o;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    mem_exp_t exp_mem[$];
    wb_exp_t  exp_wb[$];
    int n_checks = 0;
    int n_errors = 0;

    mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .MEM_pc_i(MEM_pc_i), .MEM_alu_result_i(MEM_alu_result_i),
        .MEM_rs2_data_i(MEM_rs2_data_i), .MEM_rd_add_i(MEM_rd_add_i),
        .MEM_sel_to_reg_i(MEM_sel_to_reg_i), .MEM_regwrite_i(MEM_regwrite_i),
        .MEM_RD_mem_i(MEM_RD_mem_i), .MEM_WR_mem_i(MEM_WR_mem_i),
        .MEM_mem_op_i(MEM_mem_op_i), .MEM_zero_i(MEM_zero_i),
        .MEM_branch_i(MEM_branch_i), .MEM_jump_i(MEM_jump_i),
        .MEM_pc_dest_i(MEM_pc_dest_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_rdata_i(dmem_rdata_i), .dmem_ready_i(dmem_ready_i),
        .stall_o(stall_o), .pc_src_o(pc_src_o), .pc_dest_o(pc_dest_o),
        .MEM_fwd_data_o(MEM_fwd_data_o), .WB_rd_add_o(WB_rd_add_o),
        .WB_regwrite_o(WB_regwrite_o), .WB_wdata_o(WB_wdata_o),
        .misalign_o(misalign_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented request against the queue head and
    // every writeback against the WB queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (dmem_req_o) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_unexpected_req", 32'd1, 32'd0);
                end else begin
                    chk("mem_addr", dmem_addr_o, exp_mem[0].addr);
                    chk("mem_we", {31'd0, dmem_we_o}, {31'd0, exp_mem[0].we});
                    if (exp_mem[0].we) begin
                        chk("mem_be", {28'd0, dmem_be_o}, {28'd0, exp_mem[0].be});
                        chk("mem_wdata", dmem_wdata_o, exp_mem[0].wdata);
                    end
                    if (dmem_ready_i) void'(exp_mem.pop_front());
                end
            end
            if (WB_regwrite_o) begin
                if (exp_wb.size() == 0) begin
                    chk("wb_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("wb_rd", {27'd0, WB_rd_add_o}, {27'd0, exp_wb[0].rd});
                    chk("wb_data", WB_wdata_o, exp_wb[0].data);
                    void'(exp_wb.pop_front());
                end
            end
        end
    end

    task automatic nop();
        MEM_pc_i = 0; MEM_alu_result_i = 0; MEM_rs2_data_i = 0; MEM_rd_add_i = 0;
        MEM_sel_to_reg_i = 0; MEM_regwrite_i = 0; MEM_RD_mem_i = 0; MEM_WR_mem_i = 0;
        MEM_mem_op_i = 0; MEM_zero_i = 0; MEM_branch_i = 0; MEM_jump_i = 0;
        MEM_pc_dest_i = 0; dmem_ready_i = 0; dmem_rdata_i = 0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the instruction retires.
    task automatic run(
        input logic [31:0] pc, alu, rs2, input logic [4:0] rd, input logic [1:0] sel,
        input logic rw, rdm, wrm, input logic [2:0] f3, input logic z, br, jmp,
        input logic [31:0] dest, input int lat, input logic [31:0] rdata,
        input logic exp_pcsrc, input logic wb_v, input logic [31:0] wb_d,
        input logic mem_v, input logic [31:0] m_addr, input logic [3:0] m_be,
        input logic [31:0] m_wd, input logic exp_mis);
        MEM_pc_i = pc; MEM_alu_result_i = alu; MEM_rs2_data_i = rs2; MEM_rd_add_i = rd;
        MEM_sel_to_reg_i = sel; MEM_regwrite_i = rw; MEM_RD_mem_i = rdm; MEM_WR_mem_i = wrm;
        MEM_mem_op_i = {1'b0, f3}; MEM_zero_i = z; MEM_branch_i = br; MEM_jump_i = jmp;
        MEM_pc_dest_i = dest; dmem_rdata_i = rdata; dmem_ready_i = (lat == 0);
        if (mem_v) exp_mem.push_back('{we: wrm, addr: m_addr, be: m_be, wdata: m_wd});
        if (wb_v)  exp_wb.push_back('{rd: rd, data: wb_d});
        @(negedge clk);
        chk("pc_src", {31'd0, pc_src_o}, {31'd0, exp_pcsrc});
        if (exp_pcsrc) chk("pc_dest", pc_dest_o, dest);
        chk("fwd_data", MEM_fwd_data_o, alu);
        for (int c = 0; c < lat; c++) begin
            if (c > 0) @(negedge clk);
            chk("stall_hi", {31'd0, stall_o}, 32'd1);
            @(posedge clk); #1;
            if (c == lat - 1) dmem_ready_i = 1'b1;
        end
        if (lat > 0) @(negedge clk);
        chk("stall_lo", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        chk("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
        nop();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        chk("rst_pcsrc", {31'd0, pc_src_o}, 32'd0);
        chk("rst_wb_rw", {31'd0, WB_regwrite_o}, 32'd0);
        chk("rst_wb_data", WB_wdata_o, 32'd0);
        chk("rst_wb_rd", {27'd0, WB_rd_add_o}, 32'd0);
        chk("rst_be", {28'd0, dmem_be_o}, 32'd0);
        chk("rst_mis", {31'd0, misalign_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // SW 0x100, zero-latency; store forces regwrite off
        run(32'h0, 32'h100, 32'hDEADBEEF, 5'd2, 2'b00, 1, 0, 1, 3'b010, 0, 0, 0, 32'h0,
            0, 32'h0, 0, 0, 32'h0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0);
        // LB 0x203 with 3-cycle latency
        run(32'h4, 32'h203, 32'h0, 5'd5, 2'b01, 1, 1, 0, 3'b000, 0, 0, 0, 32'h0,
            3, 32'h80FFFF12, 0, 1, 32'hFFFFFF80, 1, 32'h200, 4'b0000, 32'h0, 0);
        // SH 0x2 then LHU 0x2 back-to-back
        run(32'h8, 32'h2, 32'h1234ABCD, 5'd6, 2'b00, 0, 0, 1, 3'b001, 0, 0, 0, 32'h0,
            1, 32'h0, 0, 0, 32'h0, 1, 32'h0, 4'b1100, 32'hABCDABCD, 0);
        run(32'hC, 32'h2, 32'h0, 5'd7, 2'b01, 1, 1, 0, 3'b101, 0, 0, 0, 32'h0,
            0, 32'hABCD0000, 0, 1, 32'h0000ABCD, 1, 32'h0, 4'b0000, 32'h0, 0);
        // BEQ taken / not taken, JAL link value
        run(32'h20, 32'h0, 32'h0, 5'd0, 2'b00, 0, 0, 0, 3'b000, 1, 1, 0, 32'h40,
            0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0);
        run(32'h24, 32'h5, 32'h0, 5'd0, 2'b00, 0, 0, 0, 3'b000, 0, 1, 0, 32'h40,
            0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0);
        run(32'h10, 32'h0, 32'h0, 5'd1, 2'b10, 1, 0, 0, 3'b000, 0, 0, 1, 32'h80,
            0, 32'h0, 1, 1, 32'h14, 0, 32'h0, 4'b0, 32'h0, 0);
        // ALU pass-through
        run(32'h30, 32'h1234, 32'h0, 5'd3, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0, 32'h0,
            0, 32'h0, 0, 1, 32'h1234, 0, 32'h0, 4'b0, 32'h0, 0);
        // SB 0x1 with 2-cycle latency
        run(32'h34, 32'h1, 32'h00000077, 5'd4, 2'b00, 1, 0, 1, 3'b000, 0, 0, 0, 32'h0,
            2, 32'h0, 0, 0, 32'h0, 1, 32'h0, 4'b0010, 32'h77777777, 0);
        // LBU 0x101, LH 0x100
        run(32'h38, 32'h101, 32'h0, 5'd10, 2'b01, 1, 1, 0, 3'b100, 0, 0, 0, 32'h0,
            0, 32'h0000F000, 0, 1, 32'h000000F0, 1, 32'h100, 4'b0, 32'h0, 0);
        run(32'h3C, 32'h100, 32'h0, 5'd11, 2'b01, 1, 1, 0, 3'b001, 0, 0, 0, 32'h0,
            1, 32'h00008001, 0, 1, 32'hFFFF8001, 1, 32'h100, 4'b0, 32'h0, 0);
        // pc+4 wrap
        run(32'hFFFFFFFC, 32'h0, 32'h0, 5'd12, 2'b10, 1, 0, 0, 3'b000, 0, 0, 0, 32'h0,
            0, 32'h0, 0, 1, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0);
        // RD and WR both set: store wins, no writeback
        run(32'h40, 32'h208, 32'hCAFE0000, 5'd13, 2'b01, 1, 1, 1, 3'b010, 0, 0, 0, 32'h0,
            0, 32'h55, 0, 0, 32'h0, 1, 32'h208, 4'b1111, 32'hCAFE0000, 0);
        // LW 0x6 misaligned
`ifdef MEM_MISALIGN_TRAP_EN
        run(32'h44, 32'h6, 32'h0, 5'd14, 2'b01, 1, 1, 0, 3'b010, 0, 0, 0, 32'h0,
            0, 32'hCAFEF00D, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 1);
`else
        run(32'h44, 32'h6, 32'h0, 5'd14, 2'b01, 1, 1, 0, 3'b010, 0, 0, 0, 32'h0,
            0, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 1, 32'h4, 4'b0, 32'h0, 0);
`endif
        run(32'h48, 32'h99, 32'h0, 5'd15, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0, 32'h0,
            0, 32'h0, 0, 1, 32'h99, 0, 32'h0, 4'b0, 32'h0, 0);
        // Illegal branch + load: redirect and access both happen
        run(32'h50, 32'h10, 32'h0, 5'd16, 2'b01, 1, 1, 0, 3'b010, 1, 1, 0, 32'h200,
            1, 32'h11223344, 1, 1, 32'h11223344, 1, 32'h10, 4'b0, 32'h0, 0);

        // Reset while waiting abandons the access
        MEM_alu_result_i = 32'h300; MEM_rd_add_i = 5'd9; MEM_sel_to_reg_i = 2'b01;
        MEM_regwrite_i = 1; MEM_RD_mem_i = 1; MEM_mem_op_i = 4'b0010; dmem_ready_i = 0;
        exp_mem.push_back('{we: 1'b0, addr: 32'h300, be: 4'b0, wdata: 32'h0});
        @(negedge clk);
        chk("wait_stall", {31'd0, stall_o}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstw_wb_rw", {31'd0, WB_regwrite_o}, 32'd0);
        rst = 1'b0;
        nop();
        exp_mem.delete();
        @(negedge clk);
        chk("rstw_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rstw_stall", {31'd0, stall_o}, 32'd0);
        @(posedge clk); #1;
        run(32'h60, 32'hABC, 32'h0, 5'd17, 2'b00, 1, 0, 0, 3'b000, 0, 0, 0, 32'h0,
            0, 32'h0, 0, 1, 32'hABC, 0, 32'h0, 4'b0, 32'h0, 0);

        for (int i = 0; i < 20 && (exp_mem.size() != 0 || exp_wb.size() != 0); i++)
            @(posedge clk);
        #1;
        chk("mem_queue_drained", exp_mem.size(), 32'd0);
        chk("wb_queue_drained", exp_wb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline. Sits directly downstream of the execute stage and consumes its EX/MEM register outputs.
- Resolves branches and jumps, and drives a request/ready data-memory port. Handles byte, half and word loads and stores.
- Stalls the front of the pipe while an access is outstanding. Owns the MEM/WB pipeline register.

Parameters:
- DATA_WIDTH, 32, datapath width (only 32 supported)
- ADDR_WIDTH, 32, data-memory byte-address width

Ports:
- clk  in  1  clock
- rst  in  1  reset
- MEM_pc_i  in  32  instruction PC
- MEM_alu_result_i  in  32  ALU result (address for loads/stores)
- MEM_rs2_data_i  in  32  store data
- MEM_rd_add_i  in  5  destination register
- MEM_sel_to_reg_i  in  2  writeback select: 00 alu, 01 mem, 10 pc+4
- MEM_regwrite_i  in  1  register write enable
- MEM_RD_mem_i  in  1  load
- MEM_WR_mem_i  in  1  store
- MEM_mem_op_i  in  4  [2:0] = funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU); [3] reserved 0
- MEM_zero_i  in  1  ALU zero flag
- MEM_branch_i  in  1  conditional branch
- MEM_jump_i  in  1  jump
- MEM_pc_dest_i  in  32  branch/jump target
- dmem_req_o  out  1  access request
- dmem_we_o  out  1  write enable
- dmem_addr_o  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_rdata_i  in  32  read data, valid with ready
- dmem_ready_i  in  1  access complete
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- pc_src_o  out  1  redirect fetch, flush younger stages
- pc_dest_o  out  32  redirect target
- MEM_fwd_data_o  out  32  forwarding value (combinational alu_result)
- WB_rd_add_o  out  5  registered
- WB_regwrite_o  out  1  registered
- WB_wdata_o  out  32  registered writeback data
- misalign_o  out  1  registered; feature-dependent

Behaviour:
- Interface rule: one clock, clk; rst is synchronous and active-high.
- Reset:
  - State returns to IDLE.
  - dmem_req_o, dmem_we_o, stall_o and pc_src_o are 0.
  - All WB_* outputs and misalign_o are 0; dmem_be_o is 0.
  - Reset during WAIT abandons the access. The request drops on the next edge.
- Access: acc = RD | WR. If both are set, the store wins.
- IDLE:
  - If acc, drive dmem_req_o combinationally from the inputs in the same cycle.
  - If dmem_ready_i is also 1: access completes with zero stall, and the MEM/WB register loads on this edge.
  - Otherwise: stall_o = 1 combinationally, latch addr/be/wdata/we/op/rd/sel/pc, go to WAIT.
- WAIT:
  - dmem_* outputs are driven from the latched copy and held stable; stall_o = 1.
  - On dmem_ready_i: stall_o = 0, the MEM/WB register loads using the latched control and dmem_rdata_i, go to IDLE.
  - Back-to-back accesses are permitted on the following cycle.
- Stalled cycles: the MEM/WB register takes a bubble (WB_regwrite_o = 0).
- Non-memory instructions: single-cycle pass-through to MEM/WB.
- Store byte enables:
  - B: 4'b0001 << addr[1:0]; data {4{rs2[7:0]}}.
  - H: 4'b0011 << {addr[1],1'b0}; data {2{rs2[15:0]}}.
  - W: 4'b1111.
- Load extract: shift rdata right by addr[1:0]*8. Sign-extend for B/H; zero-extend for BU/HU.
- WB_wdata_o select: 00 alu, 01 extracted load, 10 pc+4 (32-bit wrap).
- Branch/jump resolution:
  - pc_src_o = jump | (branch & zero), combinational; pc_dest_o = MEM_pc_dest_i.
  - Branches never access memory. If branch/jump and acc are both set, treat as illegal: the redirect is still taken and the access is still performed.
- Store to rd: regwrite is forced to 0.

Optional Feature:
- MEM_MISALIGN_TRAP_EN defined:
  - H with addr[0] = 1, or W with addr[1:0] != 0, suppresses dmem_req_o and writeback.
  - misalign_o pulses 1 for one cycle on the MEM/WB edge; no stall.
- Undefined:
  - Misalignment is ignored; low address bits are masked per the byte-enable rules.
  - misalign_o is tied 0.

Decomposition:
- Package mem_pkg: mem_op funct3 codes, sel_to_reg codes, FSM state enum {IDLE, WAIT}.
- Sub-module lsu_align (combinational):
  - Store side: be/wdata generation.
  - Load side: load extract and extend.

Test Plan:
1. SW addr 0x100, data 0xDEADBEEF, ready same cycle -> be=1111, wdata=0xDEADBEEF, stall_o never 1.
2. LB addr 0x203, rdata 0x80FF_FF12, ready after 3 cycles -> stall_o high 3 cycles, WB bubbles, then WB_wdata_o=0xFFFFFF80.
3. SH addr 0x2, rs2 0x1234ABCD -> be=1100, wdata=0xABCDABCD; LHU same addr, rdata 0xABCD0000 -> 0x0000ABCD.
4. BEQ zero=1, pc_dest 0x40 -> pc_src_o=1, pc_dest_o=0x40; zero=0 -> pc_src_o=0; JAL with sel 10, pc 0x10 -> WB_wdata_o=0x14.
5. rst asserted in WAIT -> next edge: dmem_req_o=0, stall_o=0, WB_regwrite_o=0, state IDLE.
6. With MEM_MISALIGN_TRAP_EN: LW addr 0x6 -> no dmem_req_o, misalign_o pulses once, WB_regwrite_o=0.
